pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/PC width.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h8000_0000, first fetch address (XLEN bits).
REQ-003 SHALL have parameter CNT_W, default 32, fetch counter width.
REQ-004 SHALL have ports, in this order:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- stall  in  1  hold the current PC.
- jump_valid  in  1  branch/jump redirect request.
- jump_pc  in  XLEN  branch/jump target.
- trap_valid  in  1  trap/exception redirect request.
- trap_pc  in  XLEN  trap handler target.
- halt  in  1  stop fetching.
- req_valid  out  1  fetch request valid.
- req_ready  in  1  instruction memory accepts the request.
- pc  out  XLEN  current fetch address.
- mis_valid  out  1  one-cycle pulse when a misaligned target is rejected.
- mis_addr  out  XLEN  the rejected target.
- fetch_cnt  out  CNT_W  count of accepted fetch requests.

Function
REQ-005 SHALL implement the states BOOT, RUN and HALTED.
REQ-006 In BOOT, req_valid SHALL be 0; the next state SHALL be RUN unconditionally, so the first request appears one cycle after rst deasserts.
REQ-007 In RUN, req_valid SHALL be 1; in BOOT and HALTED it SHALL be 0.
REQ-008 A fetch SHALL be accepted in a cycle where req_valid=1 and req_ready=1.
REQ-009 Next-PC priority in RUN SHALL be, highest first: trap_valid, jump_valid, halt, stall, accepted fetch, hold.
REQ-010 When trap_valid=1 (any state), pc SHALL load trap_pc and the state SHALL become RUN, if trap_pc[1:0]==0.
REQ-011 When jump_valid=1, trap_valid=0 and the state is RUN, pc SHALL load jump_pc if jump_pc[1:0]==0.
REQ-012 A redirect SHALL replace the current request even if it was accepted that same cycle; fetch_cnt SHALL still count that acceptance.
REQ-013 For a misaligned redirect target (selected target bits[1:0]!=0):
- pc SHALL be unchanged;
- mis_valid SHALL be 1 for the next cycle only;
- mis_addr SHALL load the target;
- the state SHALL become HALTED.
REQ-014 When halt=1 in RUN with no redirect, the state SHALL become HALTED and pc SHALL hold.
REQ-015 When stall=1 in RUN with no redirect or halt, pc SHALL hold and req_valid SHALL stay 1.
REQ-016 On an accepted fetch with no redirect, halt or stall, pc SHALL become pc+4, modulo 2^XLEN, wrapping silently.
REQ-017 In RUN with req_ready=0 and no other event, pc SHALL hold; req_valid and pc SHALL stay stable until acceptance.
REQ-018 In HALTED, pc SHALL hold; jump_valid, halt and stall SHALL be ignored; only trap_valid exits the state.
REQ-019 fetch_cnt SHALL increment by 1 per accepted fetch and wrap from all-ones to 0.
REQ-020 Outputs SHALL be registered, except req_valid, which SHALL be decoded from the state register only.

Reset
REQ-021 While rst=1: state=BOOT, pc=RESET_VECTOR, req_valid=0, mis_valid=0, mis_addr=0, fetch_cnt=0.
REQ-022 rst asserted mid-operation (RUN or HALTED, including with redirects pending) SHALL force the REQ-021 values immediately, regardless of clk.

Verification
REQ-023 Release reset with req_ready=1 held for 4 cycles -> pc sequence 80000000, 80000000 (BOOT), 80000004, 80000008; fetch_cnt=3.
REQ-024 With pc=80000010: req_ready=0 for 3 cycles, then jump_valid=1 with jump_pc=80000100 and trap_valid=1 with trap_pc=80000200 in the same cycle -> pc holds 80000010 during the wait, then becomes 80000200.
REQ-025 jump_pc=80000102 in RUN -> pc unchanged, mis_valid=1 for exactly one cycle, mis_addr=80000102, state HALTED, req_valid=0; a later trap_pc=80000300 -> RUN at 80000300.
REQ-026 XLEN=32 with a trap redirect to FFFFFFFC and an accepted fetch -> pc=00000000.
REQ-027 CNT_W=4 with 17 accepted fetches -> fetch_cnt=1.
REQ-028 rst asserted asynchronously between clk edges while in RUN -> pc=80000000 and req_valid=0 before the next edge.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch program-counter generator: boot/run/halt sequencing, trap and jump
// redirects with alignment check, and a running count of accepted fetches.
//
// state   | meaning
// --------+--------------------------------------------------------------
// BOOT    | first cycle after reset, no request issued yet
// RUN     | issuing fetch requests at pc
// HALTED  | fetch stopped (halt or rejected target); only a trap resumes
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000,
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             jump_valid,
    input  logic [XLEN-1:0]  jump_pc,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_pc,
    input  logic             halt,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [XLEN-1:0]  pc,
    output logic             mis_valid,
    output logic [XLEN-1:0]  mis_addr,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t          state;
    logic            accept;
    logic            redir;
    logic            redir_mis;
    logic [XLEN-1:0] redir_tgt;

    assign req_valid = (state == ST_RUN);

    // Trap wins in every state; a jump only counts while running.
    always_comb begin
        accept    = req_valid & req_ready;
        redir     = trap_valid | (jump_valid & (state == ST_RUN));
        redir_tgt = trap_valid ? trap_pc : jump_pc;
        redir_mis = redir & (redir_tgt[1:0] != 2'b00);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_BOOT;
            pc        <= RESET_VECTOR;
            mis_valid <= 1'b0;
            mis_addr  <= '0;
            fetch_cnt <= '0;
        end else begin
            mis_valid <= 1'b0;
            // An accepted request is counted even if it is squashed below.
            if (accept) begin
                fetch_cnt <= fetch_cnt + CNT_ONE;
            end
            if (redir) begin
                if (redir_mis) begin
                    mis_valid <= 1'b1;
                    mis_addr  <= redir_tgt;
                    state     <= ST_HALTED;
                end else begin
                    pc    <= redir_tgt;
                    state <= ST_RUN;
                end
            end else begin
                case (state)
                    ST_BOOT: begin
                        state <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (halt) begin
                            state <= ST_HALTED;
                        end else if (!stall && accept) begin
                            pc <= pc + PC_STEP;
                        end
                    end
                    ST_HALTED: begin
                        state <= ST_HALTED;
                    end
                    default: begin
                        state <= ST_BOOT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// compared against a rule-level reference model of the fetch sequencer.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        jump_valid;
    logic [31:0] jump_pc;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic        halt;
    logic        req_ready;
    logic        req_valid;
    logic [31:0] pc;
    logic        mis_valid;
    logic [31:0] mis_addr;
    logic [31:0] fetch_cnt;
    logic        req_valid4;
    logic [31:0] pc4;
    logic        mis_valid4;
    logic [31:0] mis_addr4;
    logic [3:0]  fetch_cnt4;

    int checks = 0;
    int errors = 0;

    pc_gen dut (
        .clk(clk), .rst(rst), .stall(stall),
        .jump_valid(jump_valid), .jump_pc(jump_pc),
        .trap_valid(trap_valid), .trap_pc(trap_pc),
        .halt(halt), .req_valid(req_valid), .req_ready(req_ready),
        .pc(pc), .mis_valid(mis_valid), .mis_addr(mis_addr),
        .fetch_cnt(fetch_cnt)
    );

    pc_gen #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall),
        .jump_valid(jump_valid), .jump_pc(jump_pc),
        .trap_valid(trap_valid), .trap_pc(trap_pc),
        .halt(halt), .req_valid(req_valid4), .req_ready(req_ready),
        .pc(pc4), .mis_valid(mis_valid4), .mis_addr(mis_addr4),
        .fetch_cnt(fetch_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode is one of "boot", "run", "halted".
    string       m_mode;
    logic [31:0] m_pc;
    logic        m_mis_v;
    logic [31:0] m_mis_a;
    logic [31:0] m_cnt;
    logic [3:0]  m_cnt4;

    function automatic void model_reset();
        m_mode  = "boot";
        m_pc    = 32'h8000_0000;
        m_mis_v = 1'b0;
        m_mis_a = 32'h0;
        m_cnt   = 32'h0;
        m_cnt4  = 4'h0;
    endfunction

    function automatic void model_step();
        bit accepted;
        accepted = (m_mode == "run") && req_ready;
        if (accepted) begin
            m_cnt  = m_cnt + 1;
            m_cnt4 = m_cnt4 + 1;
        end
        m_mis_v = 1'b0;
        if (trap_valid) begin
            if (trap_pc % 4 == 0) begin
                m_pc   = trap_pc;
                m_mode = "run";
            end else begin
                m_mis_v = 1'b1;
                m_mis_a = trap_pc;
                m_mode  = "halted";
            end
        end else if (m_mode == "boot") begin
            m_mode = "run";
        end else if (m_mode == "run") begin
            if (jump_valid) begin
                if (jump_pc % 4 == 0) begin
                    m_pc = jump_pc;
                end else begin
                    m_mis_v = 1'b1;
                    m_mis_a = jump_pc;
                    m_mode  = "halted";
                end
            end else if (halt) begin
                m_mode = "halted";
            end else if (!stall && accepted) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endfunction

    task automatic idle_inputs();
        stall = 0; jump_valid = 0; jump_pc = 0; trap_valid = 0;
        trap_pc = 0; halt = 0; req_ready = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pc !== 32'h8000_0000) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h8000_0000); end
        checks++;
        if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
        checks++;
        if (mis_valid !== 1'b0 || mis_addr !== 32'h0) begin errors++; $display("FAIL reset_mis: got %b/%h expected 0/0", mis_valid, mis_addr); end
        checks++;
        if (fetch_cnt !== 32'h0 || fetch_cnt4 !== 4'h0) begin errors++; $display("FAIL reset_cnt: got %h/%h expected 0/0", fetch_cnt, fetch_cnt4); end
    endtask

    task automatic release_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (req_valid !== 1'b0 || pc !== m_pc) begin errors++; $display("FAIL boot_state: got rv=%b pc=%h expected rv=0 pc=%h", req_valid, pc, m_pc); end
    endtask

    task automatic test_boot_seq();
        release_reset();
        req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (pc !== m_pc || req_valid !== 1'b1 || fetch_cnt !== m_cnt) begin
                errors++;
                $display("FAIL boot_seq[%0d]: got pc=%h rv=%b cnt=%0d expected pc=%h rv=1 cnt=%0d", i, pc, req_valid, fetch_cnt, m_pc, m_cnt);
            end
        end
        checks++;
        if (fetch_cnt !== 32'd3 || pc !== 32'h8000_000C) begin errors++; $display("FAIL boot_final: got pc=%h cnt=%0d expected pc=8000000c cnt=3", pc, fetch_cnt); end
    endtask

    task automatic test_wait_redirect();
        step();
        req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pc !== 32'h8000_0010 || req_valid !== 1'b1) begin errors++; $display("FAIL wait_hold[%0d]: got pc=%h rv=%b expected pc=80000010 rv=1", i, pc, req_valid); end
        end
        jump_valid = 1; jump_pc = 32'h8000_0100;
        trap_valid = 1; trap_pc = 32'h8000_0200;
        step();
        idle_inputs();
        checks++;
        if (pc !== 32'h8000_0200 || pc !== m_pc) begin errors++; $display("FAIL trap_over_jump: got %h expected %h", pc, m_pc); end
        checks++;
        if (fetch_cnt !== m_cnt) begin errors++; $display("FAIL wait_cnt: got %0d expected %0d", fetch_cnt, m_cnt); end
    endtask

    task automatic test_misaligned();
        req_ready = 1; jump_valid = 1; jump_pc = 32'h8000_0102;
        step();
        idle_inputs();
        checks++;
        if (pc !== 32'h8000_0200 || mis_valid !== 1'b1 || mis_addr !== 32'h8000_0102 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL mis_jump: got pc=%h mv=%b ma=%h rv=%b expected pc=80000200 mv=1 ma=80000102 rv=0", pc, mis_valid, mis_addr, req_valid);
        end
        checks++;
        if (fetch_cnt !== m_cnt) begin errors++; $display("FAIL mis_cnt: got %0d expected %0d", fetch_cnt, m_cnt); end
        jump_valid = 1; jump_pc = 32'h8000_0400; halt = 1; stall = 1; req_ready = 1;
        step();
        idle_inputs();
        checks++;
        if (mis_valid !== 1'b0 || req_valid !== 1'b0 || pc !== 32'h8000_0200) begin
            errors++;
            $display("FAIL halted_ignore: got mv=%b rv=%b pc=%h expected mv=0 rv=0 pc=80000200", mis_valid, req_valid, pc);
        end
        trap_valid = 1; trap_pc = 32'h8000_0300;
        step();
        idle_inputs();
        checks++;
        if (pc !== 32'h8000_0300 || req_valid !== 1'b1 || pc !== m_pc) begin errors++; $display("FAIL trap_exit: got pc=%h rv=%b expected pc=80000300 rv=1", pc, req_valid); end
    endtask

    task automatic test_wrap();
        trap_valid = 1; trap_pc = 32'hFFFF_FFFC; req_ready = 1;
        step();
        trap_valid = 0;
        checks++;
        if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_trap: got %h expected fffffffc", pc); end
        step();
        idle_inputs();
        checks++;
        if (pc !== 32'h0 || pc !== m_pc) begin errors++; $display("FAIL wrap_pc: got %h expected 00000000", pc); end
    endtask

    task automatic test_cnt_wrap();
        test_reset();
        release_reset();
        req_ready = 1;
        step();
        for (int i = 0; i < 17; i++) step();
        req_ready = 0;
        checks++;
        if (fetch_cnt4 !== 4'd1 || fetch_cnt4 !== m_cnt4) begin errors++; $display("FAIL cnt4_wrap: got %0d expected 1", fetch_cnt4); end
        checks++;
        if (fetch_cnt !== 32'd17) begin errors++; $display("FAIL cnt32_17: got %0d expected 17", fetch_cnt); end
    endtask

    task automatic test_async_reset();
        req_ready = 1;
        step();
        #2 rst = 1'b1;
        jump_valid = 1; jump_pc = 32'h1234_0000;
        #1;
        model_reset();
        checks++;
        if (pc !== 32'h8000_0000 || req_valid !== 1'b0 || fetch_cnt !== 32'h0) begin
            errors++;
            $display("FAIL async_rst_run: got pc=%h rv=%b cnt=%0d expected pc=80000000 rv=0 cnt=0", pc, req_valid, fetch_cnt);
        end
        idle_inputs();
        release_reset();
        req_ready = 1; jump_valid = 1; jump_pc = 32'h8000_0013;
        step();
        step();
        checks++;
        if (req_valid !== 1'b0 || mis_valid !== 1'b1) begin errors++; $display("FAIL halt_before_rst: got rv=%b mv=%b expected rv=0 mv=1", req_valid, mis_valid); end
        trap_valid = 1; trap_pc = 32'h8000_0800;
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (pc !== 32'h8000_0000 || mis_valid !== 1'b0 || mis_addr !== 32'h0 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_halted: got pc=%h mv=%b ma=%h rv=%b expected pc=80000000 mv=0 ma=0 rv=0", pc, mis_valid, mis_addr, req_valid);
        end
        idle_inputs();
        release_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            stall      = ($urandom % 4) == 0;
            halt       = ($urandom % 24) == 0;
            req_ready  = ($urandom % 3) != 0;
            jump_valid = ($urandom % 8) == 0;
            jump_pc    = (($urandom % 8) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            trap_valid = (m_mode == "halted") ? (($urandom % 4) == 0) : (($urandom % 30) == 0);
            trap_pc    = (($urandom % 6) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            step();
            checks++;
            if (pc !== m_pc || pc4 !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h/%h expected %h", i, pc, pc4, m_pc); end
            checks++;
            if (req_valid !== (m_mode == "run")) begin errors++; $display("FAIL rnd_req_valid[%0d]: got %b expected %b", i, req_valid, m_mode == "run"); end
            checks++;
            if (mis_valid !== m_mis_v || mis_addr !== m_mis_a) begin errors++; $display("FAIL rnd_mis[%0d]: got %b/%h expected %b/%h", i, mis_valid, mis_addr, m_mis_v, m_mis_a); end
            checks++;
            if (fetch_cnt !== m_cnt || fetch_cnt4 !== m_cnt4) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, fetch_cnt, fetch_cnt4, m_cnt, m_cnt4); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_boot_seq();
        test_wait_redirect();
        test_misaligned();
        test_wrap();
        test_cnt_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
